// File: rtl/bool_truth_scanner_if.sv
// Stimulus/capture bundle between the truth-table scanner and the lab bench.
// The scanner owns a/b/c and the status outputs; the bench owns start, d and the expected table.
interface bool_truth_scanner_if;
   logic       start;
   logic       a;
   logic       b;
   logic       c;
   logic       d;
   logic [7:0] expected;
   logic       busy;
   logic       done;
   logic [7:0] truth_table;
   logic       match;

   modport master (
      output start, d, expected,
      input  a, b, c, busy, done, truth_table, match
   );

   modport slave (
      input  start, d, expected,
      output a, b, c, busy, done, truth_table, match
   );
endinterface

// File: rtl/bool_truth_scanner.sv
// Walks {a,b,c} through all 8 vectors, samples d after a settle window,
// and compares the captured truth table against the expected one.
module bool_truth_scanner #(
   parameter int unsigned SETTLE = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   bool_truth_scanner_if.slave  scan
);

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned VEC_W   = 3;
   localparam int unsigned TBL_W   = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
   localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(7);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [VEC_W-1:0]   vec_q,   vec_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [TBL_W-1:0]   tbl_q,   tbl_d;
   logic               valid_q, valid_d;
   logic               busy_q,  busy_d;
   logic               done_q,  done_d;
   logic               window_end;

   assign window_end = (cnt_q == CNT_LAST);

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         tbl_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         tbl_q   <= tbl_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state and next-register values
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      tbl_d   = tbl_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (scan.start) begin
               state_d = SCAN;
               busy_d  = 1'b1;
               vec_d   = '0;
               cnt_d   = '0;
               tbl_d   = '0;
               valid_d = 1'b0;
            end
         end

         SCAN: begin
            if (window_end) begin
               // Last edge of this vector's window: capture d, then advance
               tbl_d[vec_q] = scan.d;
               cnt_d        = '0;
               if (vec_q == VEC_LAST) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  valid_d = 1'b1;
                  vec_d   = '0;
               end else begin
                  vec_d = vec_q + VEC_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            vec_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   assign scan.a           = vec_q[2];
   assign scan.b           = vec_q[1];
   assign scan.c           = vec_q[0];
   assign scan.busy        = busy_q;
   assign scan.done        = done_q;
   assign scan.truth_table = tbl_q;

   // Only a completed scan may report a match; follows expected while idle
   assign scan.match = valid_q & (tbl_q == scan.expected);

endmodule
